cpu_phase_ctrl: RTL and testbench

Multicycle instruction sequencer for the CPU core. It generates the one-hot phase bus t[3:0] that drives fetch, decode, execute/memory and writeback. It handshakes with memory during fetch and data-access phases, owns the architectural PC, and issues the pc_update strobe to the fetch unit. It also handles halt, memory-timeout and misaligned-branch faults.

---
 rtl/cpu_phase_ctrl.sv | 134 +++++++++++++
 tb/tb_cpu_phase_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_phase_ctrl.sv
// rtl/cpu_phase_ctrl.sv - multicycle IF/ID/EX/WB phase sequencer with PC, retire count and fault handling
module cpu_phase_ctrl #(
  parameter logic [31:0] RESET_PC = 32'hBFC00000,
  parameter int          TIMEOUT  = 16,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             mem_ack,
  input  logic             is_mem,
  input  logic             halt_req,
  input  logic             branch_taken,
  input  logic [31:0]      branch_target,
  output logic [3:0]       t,
  output logic             mem_req,
  output logic             ir_load,
  output logic             reg_we,
  output logic             pc_update,
  output logic [31:0]      pc_o,
  output logic [CNT_W-1:0] instr_count,
  output logic             halted,
  output logic             fault
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_IF,
    S_ID,
    S_EX,
    S_WB,
    S_HALT,
    S_FAULT
  } state_t;

  // Last wait-counter value before the timeout fires; counter is 8 bits since TIMEOUT <= 255.
  localparam logic [7:0]       LP_WAIT_LAST = 8'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LP_CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_next;
  logic [7:0]       r_wait;
  logic             r_is_mem;
  logic [31:0]      r_pc;
  logic [CNT_W-1:0] r_count;
  logic             w_misaligned;
  logic             w_timeout;
  logic             w_retire;

  // Next-state and phase/strobe decode from the registered state.
  always_comb begin
    w_next       = r_state;
    t            = 4'b0000;
    mem_req      = 1'b0;
    ir_load      = 1'b0;
    reg_we       = 1'b0;
    pc_update    = 1'b0;
    w_retire     = 1'b0;
    w_misaligned = branch_taken && (branch_target[1:0] != 2'b00);
    w_timeout    = (r_wait == LP_WAIT_LAST);
    case (r_state)
      S_IDLE: begin
        if (run) w_next = S_IF;
      end
      S_IF: begin
        t       = 4'b0001;
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_load = 1'b1;
          w_next  = S_ID;
        end else if (w_timeout) begin
          w_next = S_FAULT;
        end
      end
      S_ID: begin
        t      = 4'b0010;
        w_next = halt_req ? S_HALT : S_EX;
      end
      S_EX: begin
        t = 4'b0100;
        if (r_is_mem) begin
          mem_req = 1'b1;
          if (mem_ack)        w_next = S_WB;
          else if (w_timeout) w_next = S_FAULT;
        end else begin
          w_next = S_WB;
        end
      end
      S_WB: begin
        t = 4'b1000;
        if (w_misaligned) begin
          // A misaligned redirect kills the instruction before it retires.
          w_next = S_FAULT;
        end else begin
          reg_we    = 1'b1;
          pc_update = 1'b1;
          w_retire  = 1'b1;
          w_next    = run ? S_IF : S_IDLE;
        end
      end
      S_HALT:  w_next = S_HALT;
      S_FAULT: w_next = S_FAULT;
      default: w_next = S_IDLE;
    endcase
  end

  // State register, memory wait counter, PC and retire counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_wait   <= 8'd0;
      r_is_mem <= 1'b0;
      r_pc     <= RESET_PC;
      r_count  <= '0;
    end else begin
      r_state <= w_next;
      // Counter restarts on every phase change, so IF and EX each get a full budget.
      if (w_next != r_state)       r_wait <= 8'd0;
      else if (mem_req && !mem_ack) r_wait <= r_wait + 8'd1;
      // Memory-access flag is captured at decode so EX behaviour is a function of registers.
      if (r_state == S_ID) r_is_mem <= is_mem;
      if (w_retire) begin
        r_pc    <= branch_taken ? branch_target : r_pc + 32'd4;
        r_count <= r_count + LP_CNT_ONE;
      end
    end
  end

  assign pc_o        = r_pc;
  assign instr_count = r_count;
  assign halted      = (r_state == S_HALT);
  assign fault       = (r_state == S_FAULT);

endmodule

// File: tb/tb_cpu_phase_ctrl.sv
// tb/tb_cpu_phase_ctrl.sv - directed self-checking bench for cpu_phase_ctrl
module tb_cpu_phase_ctrl;

  localparam logic [31:0] RST_PC = 32'hBFC00000;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic        mem_ack;
  logic        is_mem;
  logic        halt_req;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [3:0]  t;
  logic        mem_req;
  logic        ir_load;
  logic        reg_we;
  logic        pc_update;
  logic [31:0] pc_o;
  logic [31:0] instr_count;
  logic        halted;
  logic        fault;

  int checks   = 0;
  int failures = 0;

  cpu_phase_ctrl #(
    .RESET_PC(32'hBFC00000),
    .TIMEOUT (16),
    .CNT_W   (32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .run          (run),
    .mem_ack      (mem_ack),
    .is_mem       (is_mem),
    .halt_req     (halt_req),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .t            (t),
    .mem_req      (mem_req),
    .ir_load      (ir_load),
    .reg_we       (reg_we),
    .pc_update    (pc_update),
    .pc_o         (pc_o),
    .instr_count  (instr_count),
    .halted       (halted),
    .fault        (fault)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; run = 1'b0; mem_ack = 1'b0; is_mem = 1'b0;
    halt_req = 1'b0; branch_taken = 1'b0; branch_target = 32'd0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; run = 1'b0; mem_ack = 1'b0; is_mem = 1'b0;
    halt_req = 1'b0; branch_taken = 1'b0; branch_target = 32'd0;
    tick();
    tick();
    checks++; if (t !== 4'b0000) begin failures++; $display("FAIL reset_t got=%b exp=0000", t); end
    checks++; if (pc_o !== RST_PC) begin failures++; $display("FAIL reset_pc got=%h exp=%h", pc_o, RST_PC); end
    checks++; if (instr_count !== 32'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", instr_count); end
    checks++; if ({mem_req, ir_load, reg_we, pc_update} !== 4'b0000) begin
      failures++; $display("FAIL reset_strobes got=%b exp=0000", {mem_req, ir_load, reg_we, pc_update}); end
    checks++; if ({halted, fault} !== 2'b00) begin failures++; $display("FAIL reset_status got=%b exp=00", {halted, fault}); end
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [3:0]  exp_t;
    logic [31:0] exp_pc;
    do_reset();
    run = 1'b1; mem_ack = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      exp_t = 4'(1 << ((k - 1) % 4));
      checks++; if (t !== exp_t) begin failures++; $display("FAIL b2b_t cyc=%0d got=%b exp=%b", k, t, exp_t); end
      checks++; if (pc_update !== (k % 4 == 0)) begin
        failures++; $display("FAIL b2b_pc_update cyc=%0d got=%b exp=%b", k, pc_update, (k % 4 == 0)); end
      if (k % 4 == 1) begin
        exp_pc = RST_PC + 32'(4 * ((k - 1) / 4));
        checks++; if (ir_load !== 1'b1) begin failures++; $display("FAIL b2b_ir_load cyc=%0d got=%b exp=1", k, ir_load); end
        checks++; if (pc_o !== exp_pc) begin failures++; $display("FAIL b2b_pc cyc=%0d got=%h exp=%h", k, pc_o, exp_pc); end
      end
    end
    tick();
    checks++; if (pc_o !== 32'hBFC0000C) begin failures++; $display("FAIL b2b_pc_final got=%h exp=bfc0000c", pc_o); end
    checks++; if (instr_count !== 32'd3) begin failures++; $display("FAIL b2b_count got=%0d exp=3", instr_count); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    run = 1'b1; mem_ack = 1'b1;
    for (int k = 0; k < 7; k++) tick();
    checks++; if (t !== 4'b0100) begin failures++; $display("FAIL rstmid_pre_t got=%b exp=0100", t); end
    rst = 1'b1;
    tick();
    checks++; if (t !== 4'b0000) begin failures++; $display("FAIL rstmid_t got=%b exp=0000", t); end
    checks++; if (pc_o !== RST_PC) begin failures++; $display("FAIL rstmid_pc got=%h exp=%h", pc_o, RST_PC); end
    checks++; if (instr_count !== 32'd0) begin failures++; $display("FAIL rstmid_count got=%0d exp=0", instr_count); end
    rst = 1'b0;
  endtask

  task automatic test_mem_wait();
    do_reset();
    run = 1'b1; mem_ack = 1'b1; is_mem = 1'b1;
    tick();
    tick();
    mem_ack = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 5) begin mem_ack = 1'b1; #1; end
      checks++; if (t !== 4'b0100) begin failures++; $display("FAIL memwait_t i=%0d got=%b exp=0100", i, t); end
      checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL memwait_req i=%0d got=%b exp=1", i, mem_req); end
    end
    run = 1'b0;
    tick();
    checks++; if (t !== 4'b1000) begin failures++; $display("FAIL memwait_wb_t got=%b exp=1000", t); end
    checks++; if (reg_we !== 1'b1) begin failures++; $display("FAIL memwait_wb_we got=%b exp=1", reg_we); end
    tick();
    checks++; if (t !== 4'b0000) begin failures++; $display("FAIL memwait_idle_t got=%b exp=0000", t); end
  endtask

  task automatic test_timeout();
    do_reset();
    run = 1'b1; mem_ack = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      checks++; if ({t, mem_req, fault} !== 6'b0001_1_0) begin
        failures++; $display("FAIL timeout_if i=%0d got=%b exp=000110", i, {t, mem_req, fault}); end
    end
    tick();
    checks++; if (fault !== 1'b1) begin failures++; $display("FAIL timeout_fault got=%b exp=1", fault); end
    checks++; if ({t, mem_req} !== 5'b0000_0) begin failures++; $display("FAIL timeout_outs got=%b exp=00000", {t, mem_req}); end
    mem_ack = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    checks++; if ({fault, t, mem_req} !== 6'b1_0000_0) begin
      failures++; $display("FAIL timeout_sticky got=%b exp=100000", {fault, t, mem_req}); end
    rst = 1'b1; run = 1'b0;
    tick();
    checks++; if (fault !== 1'b0) begin failures++; $display("FAIL timeout_clear got=%b exp=0", fault); end
    rst = 1'b0;
  endtask

  task automatic test_branch();
    do_reset();
    run = 1'b1; mem_ack = 1'b1;
    tick(); tick(); tick();
    branch_taken = 1'b1; branch_target = 32'h80000010;
    tick();
    checks++; if (pc_update !== 1'b1) begin failures++; $display("FAIL br_pc_update got=%b exp=1", pc_update); end
    tick();
    checks++; if (pc_o !== 32'h80000010) begin failures++; $display("FAIL br_pc got=%h exp=80000010", pc_o); end
    tick(); tick();
    branch_target = 32'h80000012;
    tick();
    checks++; if ({reg_we, pc_update} !== 2'b00) begin
      failures++; $display("FAIL br_mis_strobes got=%b exp=00", {reg_we, pc_update}); end
    tick();
    checks++; if (fault !== 1'b1) begin failures++; $display("FAIL br_mis_fault got=%b exp=1", fault); end
    checks++; if (pc_o !== 32'h80000010) begin failures++; $display("FAIL br_mis_pc got=%h exp=80000010", pc_o); end
    checks++; if (instr_count !== 32'd1) begin failures++; $display("FAIL br_mis_count got=%0d exp=1", instr_count); end
  endtask

  task automatic test_wrap();
    do_reset();
    run = 1'b1; mem_ack = 1'b1;
    branch_taken = 1'b1; branch_target = 32'hFFFFFFFC;
    for (int k = 0; k < 5; k++) tick();
    checks++; if (pc_o !== 32'hFFFFFFFC) begin failures++; $display("FAIL wrap_pre got=%h exp=fffffffc", pc_o); end
    branch_taken = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    checks++; if (pc_o !== 32'h00000000) begin failures++; $display("FAIL wrap_pc got=%h exp=00000000", pc_o); end
    checks++; if (instr_count !== 32'd2) begin failures++; $display("FAIL wrap_count got=%0d exp=2", instr_count); end
  endtask

  task automatic test_halt();
    do_reset();
    run = 1'b1; mem_ack = 1'b1;
    tick();
    halt_req = 1'b1;
    tick();
    checks++; if (reg_we !== 1'b0) begin failures++; $display("FAIL halt_we got=%b exp=0", reg_we); end
    tick();
    checks++; if ({halted, t} !== 5'b1_0000) begin failures++; $display("FAIL halt_state got=%b exp=10000", {halted, t}); end
    checks++; if (instr_count !== 32'd0) begin failures++; $display("FAIL halt_count got=%0d exp=0", instr_count); end
    checks++; if (pc_o !== RST_PC) begin failures++; $display("FAIL halt_pc got=%h exp=%h", pc_o, RST_PC); end
    halt_req = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    checks++; if ({halted, t, reg_we} !== 6'b1_0000_0) begin
      failures++; $display("FAIL halt_sticky got=%b exp=100000", {halted, t, reg_we}); end
  endtask

  task automatic test_run_drop();
    do_reset();
    run = 1'b1; mem_ack = 1'b1;
    tick();
    tick();
    run = 1'b0;
    tick();
    checks++; if (t !== 4'b0100) begin failures++; $display("FAIL drop_ex_t got=%b exp=0100", t); end
    tick();
    checks++; if ({t, reg_we} !== 5'b1000_1) begin failures++; $display("FAIL drop_wb got=%b exp=10001", {t, reg_we}); end
    tick();
    checks++; if (t !== 4'b0000) begin failures++; $display("FAIL drop_idle_t got=%b exp=0000", t); end
    checks++; if (pc_o !== 32'hBFC00004) begin failures++; $display("FAIL drop_pc got=%h exp=bfc00004", pc_o); end
    checks++; if (instr_count !== 32'd1) begin failures++; $display("FAIL drop_count got=%0d exp=1", instr_count); end
    tick();
    checks++; if ({t, mem_req} !== 5'b0000_0) begin failures++; $display("FAIL drop_stay got=%b exp=00000", {t, mem_req}); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_reset_mid();
    test_mem_wait();
    test_timeout();
    test_branch();
    test_wrap();
    test_halt();
    test_run_drop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
